axi_burst_addr_gen: RTL and testbench

- Converts one accepted AXI address-channel command into its per-beat sequence: beat address, byte-lane offset, beat index, last flag and response code.
- Covers FIXED, INCR and WRAP bursts, with burst type, size and response coded as in the shared AXI types package.
- Sits in front of slave models and the crossbar scoreboard.
- Adds legality checking, flagging illegal commands with SLVERR.

---
 rtl/axi_burst_addr_gen_pkg.sv | 51 +++++
 rtl/axi_burst_next_addr.sv | 48 ++++
 rtl/axi_burst_addr_gen.sv | 160 ++++++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI types plus the burst helper constants and wrap-window functions.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package axi_burst_addr_gen_pkg;

    typedef enum logic [2:0] {
        AXI_SIZE_1B   = 3'd0,
        AXI_SIZE_2B   = 3'd1,
        AXI_SIZE_4B   = 3'd2,
        AXI_SIZE_8B   = 3'd3,
        AXI_SIZE_16B  = 3'd4,
        AXI_SIZE_32B  = 3'd5,
        AXI_SIZE_64B  = 3'd6,
        AXI_SIZE_128B = 3'd7
    } axi_burst_size;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_type;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_response;

    localparam int AXI_4KB_PAGE_BITS  = 12;
    localparam int AXI_MAX_WRAP_BEATS = 16;

    // A legal wrap window is at most 16 beats x 128 bytes = 2KB, so it never
    // leaves its 4KB page: only the in-page offset bits take part in wrapping.
    typedef logic [AXI_4KB_PAGE_BITS-1:0] page_ofs_t;

    // Size of the wrap window in bytes: bytes_per_beat * (len + 1).
    function automatic page_ofs_t calc_wrap_bytes(input logic [2:0] size,
                                                  input logic [7:0] len);
        return ({4'b0000, len} + 12'd1) << size;
    endfunction

    // In-page offset of the wrap window's lower boundary for a given address.
    function automatic page_ofs_t calc_wrap_lower(input page_ofs_t addr,
                                                  input logic [2:0] size,
                                                  input logic [7:0] len);
        return addr & ~(calc_wrap_bytes(size, len) - 12'd1);
    endfunction

endpackage

// File: rtl/axi_burst_next_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// Latency: purely combinational.
// Backpressure: none, the caller decides when to take the new address.
module axi_burst_next_addr
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [2:0]            size,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    localparam int PB = AXI_4KB_PAGE_BITS;
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] incr_next;
    logic [7:0]            len8;
    page_ofs_t             wrap_lo;
    page_ofs_t             wrap_bytes;
    page_ofs_t             wrap_next;

    // Only wrap lengths up to 16 beats are legal, so 8 bits of len suffice.
    assign len8       = 8'(len);
    assign bytes      = ONE << size;
    // Aligning first makes an unaligned start land on the next aligned beat.
    assign incr_next  = (cur_addr & ~(bytes - ONE)) + bytes;
    assign wrap_lo    = calc_wrap_lower(start_addr[PB-1:0], size, len8);
    assign wrap_bytes = calc_wrap_bytes(size, len8);
    assign wrap_next  = cur_addr[PB-1:0] + bytes[PB-1:0];

    // Select the next address by burst type; reserved types hold the address.
    always_comb begin
        next_addr = cur_addr;
        case (axi_burst_type'(burst))
            AXI_BURST_INCR: next_addr = incr_next;
            AXI_BURST_WRAP: next_addr = {start_addr[ADDR_WIDTH-1:PB],
                                         (wrap_next == wrap_lo + wrap_bytes) ? wrap_lo : wrap_next};
            default:        next_addr = cur_addr;
        endcase
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI address command into per-beat addr/lane/idx/last/resp; optional 4KB check: AXI_BURST_4KB_CHECK_EN.
// Latency: first beat valid the cycle after cmd acceptance; one beat per cycle while beat_ready_i is high.
// Backpressure: beat outputs hold while beat_ready_i is low; cmd_ready_o is low for the whole burst.
module axi_burst_addr_gen
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    localparam int LANE_W    = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic [2:0]            cmd_size_i,
    input  logic [1:0]            cmd_burst_i,
    input  logic [ID_WIDTH-1:0]   cmd_id_i,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic [ADDR_WIDTH-1:0] beat_addr_o,
    output logic [LANE_W-1:0]     beat_lane_o,
    output logic [LEN_WIDTH-1:0]  beat_idx_o,
    output logic [ID_WIDTH-1:0]   beat_id_o,
    output logic                  beat_last_o,
    output logic [1:0]            beat_resp_o,
    output logic                  busy_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [2:0]            MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [ADDR_WIDTH-1:0] ONE      = 1;
    localparam logic [LEN_WIDTH:0]    BEAT_ONE = 1;
    localparam logic [LEN_WIDTH:0]    WRAP_MAX = (LEN_WIDTH + 1)'(AXI_MAX_WRAP_BEATS);

    logic [0:0]            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] start_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  idx_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] cmd_bytes;
    logic [LEN_WIDTH:0]    cmd_beats;
    logic                  cmd_is_wrap;
    logic                  cmd_illegal;
    logic                  beat_last;

    axi_burst_next_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_next_addr (
        .cur_addr   (addr_q),
        .start_addr (start_q),
        .size       (size_q),
        .len        (len_q),
        .burst      (burst_q),
        .next_addr  (next_addr)
    );

    assign cmd_bytes   = ONE << cmd_size_i;
    assign cmd_beats   = (LEN_WIDTH + 1)'(cmd_len_i) + BEAT_ONE;
    assign cmd_is_wrap = (axi_burst_type'(cmd_burst_i) == AXI_BURST_WRAP);

`ifdef AXI_BURST_4KB_CHECK_EN
    logic [ADDR_WIDTH-1:0] cmd_end;
    logic                  cmd_page_cross;
    // Last byte of the burst measured from the aligned start, modulo the address space.
    assign cmd_end        = (cmd_addr_i & ~(cmd_bytes - ONE))
                          + ((ADDR_WIDTH'(cmd_len_i) + ONE) << cmd_size_i) - ONE;
    assign cmd_page_cross = (axi_burst_type'(cmd_burst_i) == AXI_BURST_INCR) &&
                            (cmd_end[ADDR_WIDTH-1:AXI_4KB_PAGE_BITS] !=
                             cmd_addr_i[ADDR_WIDTH-1:AXI_4KB_PAGE_BITS]);
`else
    logic cmd_page_cross;
    assign cmd_page_cross = 1'b0;
`endif

    // Burst-wide legality, evaluated on the command as presented at acceptance.
    always_comb begin
        cmd_illegal = 1'b0;
        if (cmd_size_i > MAX_SIZE)
            cmd_illegal = 1'b1;
        if (axi_burst_type'(cmd_burst_i) == AXI_BURST_RSVD)
            cmd_illegal = 1'b1;
        if (cmd_is_wrap && ((cmd_beats < 2) || (cmd_beats > WRAP_MAX) ||
                            ((cmd_beats & (cmd_beats - BEAT_ONE)) != '0)))
            cmd_illegal = 1'b1;
        if (cmd_is_wrap && ((cmd_addr_i & (cmd_bytes - ONE)) != '0))
            cmd_illegal = 1'b1;
        if (cmd_page_cross)
            cmd_illegal = 1'b1;
    end

    assign beat_last = (idx_q == len_q);

    // Command capture, beat stepping and the IDLE/BURST state machine.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            start_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        state_q <= ST_BURST;
                        addr_q  <= cmd_addr_i;
                        start_q <= cmd_addr_i;
                        len_q   <= cmd_len_i;
                        idx_q   <= '0;
                        size_q  <= cmd_size_i;
                        burst_q <= cmd_burst_i;
                        id_q    <= cmd_id_i;
                        err_q   <= cmd_illegal;
                    end
                end
                default: begin
                    if (beat_ready_i) begin
                        if (beat_last) begin
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            // Errored bursts keep reporting the command address.
                            if (!err_q)
                                addr_q <= next_addr;
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q == ST_BURST);
    assign beat_valid_o = (state_q == ST_BURST);
    assign beat_addr_o  = addr_q;
    assign beat_lane_o  = (DATA_WIDTH > 8) ? addr_q[LANE_W-1:0] : '0;
    assign beat_idx_o   = idx_q;
    assign beat_id_o    = id_q;
    // Gated by state so the idle/reset value of last is 0.
    assign beat_last_o  = (state_q == ST_BURST) && beat_last;
    assign beat_resp_o  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Randomized and directed bench for axi_burst_addr_gen against a burst-list reference model.
// Latency: checks first beat one cycle after acceptance and idle the cycle after the last beat.
// Backpressure: random and forced beat_ready_i stalls; outputs re-checked every stalled cycle.
module tb_axi_burst_addr_gen;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int LW = 8;
    localparam int LANEW = 3;
    localparam int MAXS = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic [AW-1:0]   cmd_addr_i;
    logic [LW-1:0]   cmd_len_i;
    logic [2:0]      cmd_size_i;
    logic [1:0]      cmd_burst_i;
    logic [IW-1:0]   cmd_id_i;
    logic            beat_valid_o;
    logic            beat_ready_i;
    logic [AW-1:0]   beat_addr_o;
    logic [LANEW-1:0] beat_lane_o;
    logic [LW-1:0]   beat_idx_o;
    logic [IW-1:0]   beat_id_o;
    logic            beat_last_o;
    logic [1:0]      beat_resp_o;
    logic            busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_size_i   (cmd_size_i),
        .cmd_burst_i  (cmd_burst_i),
        .cmd_id_i     (cmd_id_i),
        .beat_valid_o (beat_valid_o),
        .beat_ready_i (beat_ready_i),
        .beat_addr_o  (beat_addr_o),
        .beat_lane_o  (beat_lane_o),
        .beat_idx_o   (beat_idx_o),
        .beat_id_o    (beat_id_o),
        .beat_last_o  (beat_last_o),
        .beat_resp_o  (beat_resp_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: is the command illegal under the burst rules?
    function automatic bit exp_err(input longint unsigned a, input int len, input int size, input int burst);
        longint unsigned bytes;
        longint unsigned last_byte;
        bit e;
        bytes = 64'd1 << size;
        e = 1'b0;
        if (size > MAXS) e = 1'b1;
        if (burst == 3) e = 1'b1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1'b1;
        if (burst == 2 && (a % bytes) != 0) e = 1'b1;
`ifdef AXI_BURST_4KB_CHECK_EN
        last_byte = ((a - (a % bytes)) + longint'(len + 1) * bytes - 1) % (64'd1 << AW);
        if (burst == 1 && (last_byte / 4096) != (a / 4096)) e = 1'b1;
`else
        last_byte = 0;
        if (last_byte != 0) e = 1'b1;
`endif
        return e;
    endfunction

    // Reference: address of beat n, from start address and beat count arithmetic.
    function automatic longint unsigned exp_addr(input longint unsigned a, input int len, input int size,
                                                 input int burst, input bit err, input int n);
        longint unsigned bytes;
        longint unsigned wb;
        longint unsigned lower;
        bytes = 64'd1 << size;
        if (err || burst == 0 || n == 0) return a;
        if (burst == 1) return ((a - (a % bytes)) + longint'(n) * bytes) % (64'd1 << AW);
        wb    = bytes * longint'(len + 1);
        lower = a - (a % wb);
        return lower + ((a - lower + longint'(n) * bytes) % wb);
    endfunction

    // Issue one command and walk its beats; stall_idx forces 3 stalled cycles
    // at that beat, rst_at asserts reset when that beat is presented.
    task automatic run_burst(input longint unsigned a, input int len, input int size, input int burst,
                             input int id, input int ready_pct, input int stall_idx, input int rst_at);
        bit err;
        bit hs;
        int n;
        int cyc;
        int stall_left;
        bit stalled;
        longint unsigned ea;
        err = exp_err(a, len, size, burst);
        cyc = 0;
        while (!cmd_ready_o && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready_o), 64'd1);
        cmd_addr_i  = AW'(a);
        cmd_len_i   = LW'(len);
        cmd_size_i  = 3'(size);
        cmd_burst_i = 2'(burst);
        cmd_id_i    = IW'(id);
        cmd_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_addr_i  = '0;
        n = 0;
        cyc = 0;
        stall_left = 0;
        stalled = 1'b0;
        while (n <= len && cyc < 2000) begin
            if (n == rst_at) begin
                rst_i = 1'b1;
                #1;
                chk("rst_valid", 64'(beat_valid_o), 64'd0);
                chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
                chk("rst_busy", 64'(busy_o), 64'd0);
                chk("rst_idx", 64'(beat_idx_o), 64'd0);
                chk("rst_addr", 64'(beat_addr_o), 64'd0);
                chk("rst_last", 64'(beat_last_o), 64'd0);
                @(negedge clk_i);
                rst_i = 1'b0;
                beat_ready_i = 1'b1;
                @(negedge clk_i);
                chk("post_rst_valid", 64'(beat_valid_o), 64'd0);
                beat_ready_i = 1'b0;
                return;
            end
            ea = exp_addr(a, len, size, burst, err, n);
            chk("beat_valid", 64'(beat_valid_o), 64'd1);
            chk("beat_addr", 64'(beat_addr_o), ea);
            chk("beat_lane", 64'(beat_lane_o), ea % (DW / 8));
            chk("beat_idx", 64'(beat_idx_o), 64'(n));
            chk("beat_id", 64'(beat_id_o), 64'(id));
            chk("beat_last", 64'(beat_last_o), 64'(n == len));
            chk("beat_resp", 64'(beat_resp_o), err ? 64'd2 : 64'd0);
            chk("busy", 64'(busy_o), 64'd1);
            chk("cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
            if (n == stall_idx && !stalled) begin
                stalled = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                beat_ready_i = 1'b0;
                stall_left--;
            end else begin
                beat_ready_i = ($urandom_range(99) < ready_pct);
            end
            hs = beat_ready_i && beat_valid_o;
            @(posedge clk_i);
            if (hs) n++;
            @(negedge clk_i);
            cyc++;
        end
        beat_ready_i = 1'b0;
        if (cyc >= 2000) chk("beat_timeout", 64'd0, 64'd1);
        chk("end_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("end_valid", 64'(beat_valid_o), 64'd0);
        chk("end_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        longint unsigned a;
        int len;
        int size;
        int burst;
        rst_i        = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_addr_i   = '0;
        cmd_len_i    = '0;
        cmd_size_i   = '0;
        cmd_burst_i  = '0;
        cmd_id_i     = '0;
        beat_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("reset_valid", 64'(beat_valid_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_addr", 64'(beat_addr_o), 64'd0);
        chk("reset_last", 64'(beat_last_o), 64'd0);
        chk("reset_resp", 64'(beat_resp_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_burst(64'h1002, 3, 2, 1, 3, 100, -1, -1);
        run_burst(64'h38, 3, 2, 2, 5, 100, -1, -1);
        run_burst(64'h40, 2, 3, 0, 9, 100, 1, -1);
        run_burst(64'h10, 2, 2, 2, 1, 70, -1, -1);
        run_burst(64'h200, 3, 4, 1, 2, 70, -1, -1);
        run_burst(64'h44, 3, 2, 3, 4, 100, -1, -1);
        run_burst(64'h0FF8, 1, 3, 1, 6, 100, -1, -1);
        run_burst(64'hFFFF_FFF8, 1, 3, 1, 7, 100, -1, -1);
        run_burst(64'h800, 7, 3, 1, 11, 100, -1, 2);
        run_burst(64'h800, 7, 3, 1, 12, 100, -1, -1);

        for (int i = 0; i < 40; i++) begin
            burst = ($urandom_range(9) == 0) ? 3 : $urandom_range(2);
            size  = $urandom_range(4);
            if (burst == 2 && $urandom_range(3) != 0) begin
                len = (2 << $urandom_range(3)) - 1;
            end else begin
                len = $urandom_range(15);
            end
            case ($urandom_range(2))
                0: a = longint'($urandom);
                1: a = 64'h7000 + longint'($urandom_range(4095, 3968));
                default: a = longint'($urandom) & ~(64'd1 << size) & 64'hFFFF_FFFF;
            endcase
            if (burst == 2 && $urandom_range(3) != 0) a = a - (a % (64'd1 << size));
            run_burst(a, len, size, burst, $urandom_range(15), $urandom_range(100, 30), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
